// File: rtl/spi_slave_if.sv
// SPI mode-0 slave with one-word transmit holding buffer and single-word receive register.
// All SPI pins are resynchronised into sys_clk; SPI edges take effect about three cycles after they occur on the pins.

module spi_slave_if #(
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [DATA_W-1:0] hold_dat;
    logic              hold_full;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              reload_pend;

    logic load, sample, shift_out, cs_end;

    // cs synchroniser resets low so a frame already in progress at reset release is never mistaken for idle
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sample    = 1'b0;
        shift_out = 1'b0;
        cs_end    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    cs_end    = 1'b1;
                end else begin
                    sample = sclk_rise;
                    if (sclk_fall) begin
                        load      = reload_pend;
                        shift_out = ~reload_pend;
                    end
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // A write and a load can coincide only when the buffer is empty, so the write is kept for the next frame
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            hold_dat    <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_valid && !hold_full) begin
                hold_dat  <= tx_data;
                hold_full <= 1'b1;
            end

            if (load) begin
                tx_shift    <= hold_full ? hold_dat : '0;
                tx_underrun <= ~hold_full;
                reload_pend <= 1'b0;
                if (hold_full) begin
                    hold_full <= 1'b0;
                end
            end

            if (shift_out) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (sample) begin
                rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt     <= '0;
                    rx_data     <= {rx_shift, mosi_s};
                    rx_valid    <= 1'b1;
                    reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (cs_end) begin
                frame_err   <= (bit_cnt != '0);
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
        end
    end

    assign spi_miso    = tx_shift[DATA_W-1];
    assign spi_miso_oe = (state == SHIFT);
    assign busy        = (state == SHIFT);
    assign tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: an SPI mode-0 master model drives frames, and results are checked against hand-computed words.
module tb_spi_slave_if;

    logic        sys_clk;
    logic        rst;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        tx_underrun;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int rv_cnt   = 0;
    int fe_cnt   = 0;
    int ur_cnt   = 0;

    logic [63:0] mo_bits;
    logic [63:0] mi_bits;

    spi_slave_if #(.DATA_W(16)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (rx_valid)    rv_cnt <= rv_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic tx_write(input logic [15:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_high(input int h);
        tick(h);
        spi_cs = 1'b1;
        tick(8);
    endtask

    task automatic clock_bits(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo_bits[63];
            mo_bits  = mo_bits << 1;
            tick(h);
            mi_bits  = {mi_bits[62:0], spi_miso};
            spi_sclk = 1'b1;
            tick(h);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame16(input logic [15:0] mo, input int h);
        mo_bits = {mo, 48'h0};
        cs_low();
        clock_bits(16, h);
        cs_high(h);
    endtask

    initial begin
        int rv0, fe0, ur0;
        logic [15:0] w, m;

        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        mo_bits  = '0;
        mi_bits  = '0;
        tick(3);

        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_pulses", {29'd0, rx_valid, frame_err, tx_underrun}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_miso", {30'd0, spi_miso, spi_miso_oe}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Single frame with preloaded word
        tx_write(16'hA55A);
        chk("t1_tx_ready_full", 32'(tx_ready), 32'd0);
        rv0 = rv_cnt; fe0 = fe_cnt;
        mo_bits = {16'h1234, 48'h0};
        cs_low();
        chk("t1_tx_ready_after_cs", 32'(tx_ready), 32'd1);
        chk("t1_busy_oe", {30'd0, busy, spi_miso_oe}, 32'd3);
        clock_bits(16, 5);
        cs_high(5);
        chk("t1_miso", 32'(mi_bits[15:0]), 32'hA55A);
        chk("t1_rx_data", 32'(rx_data), 32'h1234);
        chk("t1_rx_valid_cnt", rv_cnt - rv0, 1);
        chk("t1_frame_err_cnt", fe_cnt - fe0, 0);
        chk("t1_idle", {30'd0, busy, spi_miso_oe}, 32'd0);

        // Back-to-back frames with a write during the first
        tx_write(16'h0001);
        rv0 = rv_cnt; fe0 = fe_cnt;
        mo_bits = {16'hBEEF, 16'hCAFE, 32'h0};
        cs_low();
        clock_bits(8, 5);
        tx_write(16'h8000);
        clock_bits(8, 5);
        tick(2);
        chk("t2_rx_first", 32'(rx_data), 32'hBEEF);
        clock_bits(16, 5);
        cs_high(5);
        chk("t2_rx_second", 32'(rx_data), 32'hCAFE);
        chk("t2_miso", mi_bits[31:0], 32'h0001_8000);
        chk("t2_rx_valid_cnt", rv_cnt - rv0, 2);
        chk("t2_frame_err_cnt", fe_cnt - fe0, 0);

        // Frame started with an empty buffer
        chk("t3_tx_ready", 32'(tx_ready), 32'd1);
        rv0 = rv_cnt; ur0 = ur_cnt;
        mo_bits = {16'h3C96, 48'h0};
        cs_low();
        chk("t3_underrun_at_start", ur_cnt - ur0, 1);
        clock_bits(16, 5);
        cs_high(5);
        chk("t3_miso_zero", 32'(mi_bits[15:0]), 32'h0000);
        chk("t3_rx_data", 32'(rx_data), 32'h3C96);
        chk("t3_rx_valid_cnt", rv_cnt - rv0, 1);

        // Frame aborted after 7 bits, then a clean frame
        rv0 = rv_cnt; fe0 = fe_cnt;
        mo_bits = {16'hFFFF, 48'h0};
        cs_low();
        clock_bits(7, 5);
        cs_high(5);
        chk("t4_frame_err_cnt", fe_cnt - fe0, 1);
        chk("t4_no_rx_valid", rv_cnt - rv0, 0);
        chk("t4_rx_data_kept", 32'(rx_data), 32'h3C96);
        chk("t4_busy", 32'(busy), 32'd0);
        tx_write(16'h6E21);
        rv0 = rv_cnt; fe0 = fe_cnt;
        frame16(16'hC3A5, 5);
        chk("t4_next_miso", 32'(mi_bits[15:0]), 32'h6E21);
        chk("t4_next_rx", 32'(rx_data), 32'hC3A5);
        chk("t4_next_rv", rv_cnt - rv0, 1);
        chk("t4_next_fe", fe_cnt - fe0, 0);

        // Reset in mid-frame with cs held low
        mo_bits = {16'hFFFF, 48'h0};
        cs_low();
        clock_bits(5, 5);
        rv0 = rv_cnt; fe0 = fe_cnt; ur0 = ur_cnt;
        rst = 1'b1;
        tick(3);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rx_data", 32'(rx_data), 32'h0);
        rst = 1'b0;
        clock_bits(11, 5);
        chk("t5_wait_busy", 32'(busy), 32'd0);
        chk("t5_no_pulses_low", (rv_cnt - rv0) + (fe_cnt - fe0) + (ur_cnt - ur0), 0);
        cs_high(5);
        chk("t5_no_pulses_rise", (rv_cnt - rv0) + (fe_cnt - fe0) + (ur_cnt - ur0), 0);
        rv0 = rv_cnt;
        frame16(16'h00FF, 5);
        chk("t5_rx_data", 32'(rx_data), 32'h00FF);
        chk("t5_rx_valid_cnt", rv_cnt - rv0, 1);

        // Minimum SCLK timing with random words
        for (int f = 0; f < 100; f++) begin
            w = 16'($urandom);
            m = 16'($urandom);
            tx_write(w);
            frame16(m, 4);
            chk("t6_miso", 32'(mi_bits[15:0]), 32'(w));
            chk("t6_rx_data", 32'(rx_data), 32'(m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 SHALL have parameter DATA_W, default 16, frame length in bits (legal 8..32).
REQ-002 SHALL have port sys_clk  input  1  system clock, 100 MHz, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port spi_sclk  input  1  SPI clock from master, asynchronous to sys_clk.
REQ-005 SHALL have port spi_cs  input  1  chip select from master, active-low, asynchronous.
REQ-006 SHALL have port spi_mosi  input  1  master-to-slave data, asynchronous.
REQ-007 SHALL have port spi_miso  output  1  slave-to-master data.
REQ-008 SHALL have port spi_miso_oe  output  1  MISO output enable for top-level tristate.
REQ-009 SHALL have port tx_data  input  DATA_W  word to send in a later frame.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid; write occurs when tx_valid and tx_ready are both high.
REQ-011 SHALL have port tx_ready  output  1  transmit holding buffer empty.
REQ-012 SHALL have port rx_data  output  DATA_W  last complete received word.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse, spi_cs deasserted mid-frame.
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse, frame started with empty buffer.
REQ-016 SHALL have port busy  output  1  high in SHIFT state.

Function
REQ-017 SHALL synchronize spi_sclk, spi_cs and spi_mosi through 2 flops each, then detect edges against a third registered copy; all logic SHALL use only the synchronized signals.
REQ-018 SHALL implement SPI mode 0, MSB first: sample MOSI on synchronized SCLK rise, shift MISO on synchronized SCLK fall.
REQ-019 SHALL operate correctly when SCLK high and low times are each >= 4 sys_clk cycles and the CS-fall to first SCLK rise time is >= 6 sys_clk cycles; behaviour outside this range is unspecified.
REQ-020 SHALL have states WAIT_IDLE, IDLE and SHIFT; reset enters WAIT_IDLE.
REQ-021 WAIT_IDLE -> IDLE when synchronized cs is high; no frame is accepted while in WAIT_IDLE.
REQ-022 IDLE -> SHIFT on synchronized cs falling edge; in the same cycle the tx shift register SHALL load the holding buffer and the buffer SHALL be marked empty.
REQ-023 If the buffer is empty at load, the shift register SHALL load all zeros and tx_underrun SHALL pulse once; a tx write in that same cycle is stored for the next frame (no bypass).
REQ-024 In SHIFT, a bit counter SHALL count SCLK rises 0..DATA_W-1; on the DATA_W-th rise rx_data SHALL update with the full word and rx_valid SHALL pulse in the following cycle, and the counter SHALL wrap to 0.
REQ-025 After a wrap with cs still low, the next synchronized SCLK fall SHALL reload the shift register from the buffer per REQ-022/023, giving back-to-back frames.
REQ-026 spi_miso SHALL equal the shift register MSB; spi_miso_oe SHALL be high exactly while in SHIFT.
REQ-027 Synchronized cs rise in SHIFT -> IDLE; if the counter is non-zero, frame_err SHALL pulse and rx_data/rx_valid SHALL remain unchanged.
REQ-028 rx_data SHALL hold until the next complete frame; there is no rx backpressure and an unread word is overwritten.
REQ-029 tx_ready SHALL be high when the buffer is empty, independent of state.

Reset
REQ-030 On rst high at a sys_clk edge: state WAIT_IDLE, buffer empty, shift register, counter and rx_data 0, spi_miso 0, spi_miso_oe 0, tx_ready 1, rx_valid, frame_err, tx_underrun and busy 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no pulses; if cs is still low at release, the block SHALL stay in WAIT_IDLE until cs goes high.

Verification
REQ-032 Write tx 0xA55A, then send a 16-bit frame with MOSI 0x1234 at SCLK = sys_clk/10 -> MISO bits read 0xA55A, rx_data 0x1234, one rx_valid pulse, tx_ready high again after the CS fall.
REQ-033 Write tx 0x0001, hold CS low for 32 bits with MOSI 0xBEEF then 0xCAFE, and write tx 0x8000 during the first frame -> rx_valid pulses twice (0xBEEF, 0xCAFE); MISO reads 0x0001 then 0x8000.
REQ-034 Start a frame with no tx write -> tx_underrun pulses once, MISO reads 0x0000, rx still completes.
REQ-035 Raise CS after 7 bits -> frame_err pulses once, no rx_valid, rx_data keeps its previous value; next full frame succeeds.
REQ-036 Assert rst after bit 5 with CS held low, release, finish the clocks, raise CS, send frame 0x00FF -> no pulses before CS rises, then rx_data 0x00FF.
REQ-037 Run with SCLK high/low = 4 sys_clk cycles and mid-bit MOSI glitch-free random data for 100 frames -> every rx_data and MISO word matches the model.
